// File: rtl/wfifo_wr_arbiter_if.sv
// Bundle between NREQ write-domain requesters, the shared FIFO write port and the
// arbiter: the slave modport is the arbiter's view, master is the requester/FIFO side.
interface wfifo_wr_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8
);
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          last;
  logic [NREQ*DATASIZE-1:0] data;
  logic                     full;
  logic                     winc;
  logic [DATASIZE-1:0]      wdata;
  logic [NREQ-1:0]          ack;
  logic [NREQ-1:0]          grant;
  logic                     busy;

  modport master (
    output req, last, data, full,
    input  winc, wdata, ack, grant, busy
  );

  modport slave (
    input  req, last, data, full,
    output winc, wdata, ack, grant, busy
  );
endinterface

// File: rtl/wfifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter sharing one async-FIFO write port among NREQ requesters.
// Optional WARB_BURST_LIMIT_EN: a grant is also released after MAX_BURST transferred beats.
module wfifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATASIZE  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              wclk,
  input  logic              w_rst,
  wfifo_wr_arbiter_if.slave bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [IDXW-1:0]     rr_q, rr_d;

  logic [DATASIZE-1:0] data_arr [NREQ];
  logic [IDXW-1:0]     cand_idx [NREQ];
  logic [NREQ-1:0]     cand_req;
  logic                win_found;
  logic [IDXW-1:0]     win_idx;
  logic                owner_req;
  logic                owner_last;
  logic                xfer;
  logic                burst_done;
  logic                release_pkt;

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.data[gi*DATASIZE +: DATASIZE];
    end

    // Candidate gi is the requester gi places after the rr pointer, wrapping at NREQ.
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDXW:0] sum;
      assign sum          = {1'b0, rr_q} + (IDXW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDXW+1)'(NREQ)) ? IDXW'(sum - (IDXW+1)'(NREQ))
                                                      : sum[IDXW-1:0];
      assign cand_req[gi] = bus.req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign owner_req   = bus.req[owner_q];
  assign owner_last  = bus.last[owner_q];
  assign xfer        = (state_q == LOCK) & owner_req & ~bus.full;
  assign release_pkt = xfer & (owner_last | burst_done);

`ifdef WARB_BURST_LIMIT_EN
  localparam int CNTW = $clog2(MAX_BURST + 1);

  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

  assign burst_done = (beat_cnt_q == CNTW'(MAX_BURST - 1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (release_pkt) begin
      beat_cnt_d = '0;
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  // Legal MAX_BURST is >= 1, so this is constant 0: only a last beat releases.
  assign burst_done = (MAX_BURST < 1);
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCK;
          owner_d = win_idx;
          grant_d = NREQ'(1) << win_idx;
        end
      end
      LOCK: begin
        if (release_pkt) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.winc  = xfer;
  assign bus.wdata = data_arr[owner_q];
  assign bus.ack   = xfer ? grant_q : '0;
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == LOCK);

endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// Directed and randomized bench for wfifo_wr_arbiter against a packet-level reference model.
module tb_wfifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic wclk  = 1'b0;
  logic w_rst = 1'b1;

  wfifo_wr_arbiter_if #(.NREQ(NREQ), .DATASIZE(DW)) bus ();

  wfifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .MAX_BURST(MB)) dut (
    .wclk  (wclk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  always #5 wclk = ~wclk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: whether a packet is locked, its owner, rr start point, beats this grant
  bit m_lock;
  int m_owner;
  int m_rr;
  int m_beats;

  logic [DW-1:0]   qd [NREQ][$];
  bit              ql [NREQ][$];
  bit              active [NREQ];
  logic [NREQ-1:0] last_ack;

  int            lg_own [$];
  logic [DW-1:0] lg_dat [$];
  int            ex_own [$];
  logic [DW-1:0] ex_dat [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] === 1'b1 && r < 0) r = i;
    return r;
  endfunction

  // One clock: drive inputs at posedge+1, check at posedge+2, advance model, wait for next posedge+1.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input logic [NREQ*DW-1:0] d, input logic f);
    logic [NREQ-1:0] e_grant, e_ack;
    logic            e_winc;
    logic [DW-1:0]   e_wdata;
    bit              rel;
    int              win;
    bus.req  = r;
    bus.last = l;
    bus.data = d;
    bus.full = f;
    #1;
    e_grant = '0;
    if (m_lock) e_grant[m_owner] = 1'b1;
    e_winc  = m_lock && r[m_owner] && !f;
    e_ack   = '0;
    if (e_winc) e_ack[m_owner] = 1'b1;
    e_wdata = d[m_owner*DW +: DW];
    chk("grant", 32'(bus.grant), 32'(e_grant));
    chk("winc",  32'(bus.winc),  32'(e_winc));
    chk("ack",   32'(bus.ack),   32'(e_ack));
    chk("busy",  32'(bus.busy),  32'(m_lock));
    if (e_winc) chk("wdata", 32'(bus.wdata), 32'(e_wdata));
    if (bus.winc === 1'b1) begin
      lg_own.push_back(onehot_idx(bus.ack));
      lg_dat.push_back(bus.wdata);
    end
    last_ack = e_ack;
    if (!m_lock) begin
      win = -1;
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && r[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
      if (win >= 0) begin
        m_lock  = 1'b1;
        m_owner = win;
      end
    end else if (e_winc) begin
      m_beats++;
      rel = l[m_owner];
`ifdef WARB_BURST_LIMIT_EN
      if (m_beats == MB) rel = 1'b1;
`endif
      if (rel) begin
        m_lock  = 1'b0;
        m_rr    = (m_owner + 1) % NREQ;
        m_beats = 0;
      end
    end
    @(posedge wclk);
    #1;
  endtask

  // Requesters present queued beats; only the current owner may bubble.
  task automatic qcycle(input int bub_pct, input int full_pct, input int act_pct);
    logic [NREQ-1:0]    r, l;
    logic [NREQ*DW-1:0] d;
    logic               f;
    r = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!active[i] && qd[i].size() > 0 && int'($urandom_range(99)) < act_pct) active[i] = 1'b1;
      if (active[i]) begin
        r[i] = !(m_lock && m_owner == i && int'($urandom_range(99)) < bub_pct);
        d[i*DW +: DW] = qd[i][0];
        l[i] = r[i] ? ql[i][0] : 1'($urandom);
      end else begin
        d[i*DW +: DW] = DW'($urandom);
        l[i] = 1'($urandom);
      end
    end
    f = (int'($urandom_range(99)) < full_pct);
    cycle(r, l, d, f);
    for (int i = 0; i < NREQ; i++) begin
      if (last_ack[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
        if (qd[i].size() == 0) active[i] = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int i, input logic [DW-1:0] dat, input bit lst);
    qd[i].push_back(dat);
    ql[i].push_back(lst);
  endtask

  task automatic expect_wr(input int own, input logic [DW-1:0] dat);
    ex_own.push_back(own);
    ex_dat.push_back(dat);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 32'(lg_own.size()), 32'(ex_own.size()));
    for (int i = 0; i < ex_own.size() && i < lg_own.size(); i++) begin
      chk({tag, "_own"}, 32'(lg_own[i]), 32'(ex_own[i]));
      chk({tag, "_dat"}, 32'(lg_dat[i]), 32'(ex_dat[i]));
    end
    lg_own.delete();
    lg_dat.delete();
    ex_own.delete();
    ex_dat.delete();
  endtask

  task automatic model_clear();
    m_lock  = 1'b0;
    m_owner = 0;
    m_rr    = 0;
    m_beats = 0;
    for (int i = 0; i < NREQ; i++) begin
      qd[i].delete();
      ql[i].delete();
      active[i] = 1'b0;
    end
    lg_own.delete();
    lg_dat.delete();
    ex_own.delete();
    ex_dat.delete();
  endtask

  task automatic do_reset();
    w_rst    = 1'b1;
    bus.req  = '0;
    bus.last = '0;
    bus.full = 1'b0;
    bus.data = '0;
    bus.data[DW-1:0] = 8'h5A;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'(0));
    chk("rst_winc",  32'(bus.winc),  32'(0));
    chk("rst_ack",   32'(bus.ack),   32'(0));
    chk("rst_busy",  32'(bus.busy),  32'(0));
    chk("rst_wdata", 32'(bus.wdata), 32'h5A);
    @(posedge wclk);
    #1;
    w_rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [NREQ*DW-1:0] d;
    int                 n;
    bus.req  = '0;
    bus.last = '0;
    bus.data = '0;
    bus.full = 1'b0;
    @(posedge wclk);
    #1;
    do_reset();

    // single requester, single-beat packet
    d = '0;
    d[7:0] = 8'hA5;
    cycle(4'b0001, 4'b0001, d, 1'b0);
    cycle(4'b0001, 4'b0001, d, 1'b0);
    cycle(4'b0000, 4'b0000, d, 1'b0);
    expect_wr(0, 8'hA5);
    chk_log("t1");

    // all requesting, one-beat packets: rr pointer now 1
    d = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 10; c++) cycle(4'b1111, 4'b1111, d, 1'b0);
    expect_wr(1, 8'h11);
    expect_wr(2, 8'h12);
    expect_wr(3, 8'h13);
    expect_wr(0, 8'h10);
    expect_wr(1, 8'h11);
    chk_log("t2");

    // 3-beat packet from requester 2 while requester 0 waits
    do_reset();
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h33, 1'b1);
    push_beat(0, 8'h77, 1'b1);
    active[2] = 1'b1;
    qcycle(0, 0, 0);
    active[0] = 1'b1;
    for (int c = 0; c < 8; c++) qcycle(0, 0, 0);
    expect_wr(2, 8'h11);
    expect_wr(2, 8'h22);
    expect_wr(2, 8'h33);
    expect_wr(0, 8'h77);
    chk_log("t3");

    // full stall of 5 cycles mid-packet
    do_reset();
    push_beat(2, 8'hA1, 1'b0);
    push_beat(2, 8'hA2, 1'b0);
    push_beat(2, 8'hA3, 1'b0);
    push_beat(2, 8'hA4, 1'b1);
    active[2] = 1'b1;
    for (int c = 0; c < 3; c++) qcycle(0, 0, 0);
    chk("t4_pre_stall", 32'(lg_own.size()), 32'(2));
    for (int c = 0; c < 5; c++) qcycle(0, 100, 0);
    chk("t4_in_stall", 32'(lg_own.size()), 32'(2));
    for (int c = 0; c < 4; c++) qcycle(0, 0, 0);
    expect_wr(2, 8'hA1);
    expect_wr(2, 8'hA2);
    expect_wr(2, 8'hA3);
    expect_wr(2, 8'hA4);
    chk_log("t4");

    // owner bubbles for 2 cycles mid-packet
    do_reset();
    push_beat(1, 8'hB1, 1'b0);
    push_beat(1, 8'hB2, 1'b0);
    push_beat(1, 8'hB3, 1'b1);
    active[1] = 1'b1;
    for (int c = 0; c < 2; c++) qcycle(0, 0, 0);
    for (int c = 0; c < 2; c++) qcycle(100, 0, 0);
    for (int c = 0; c < 4; c++) qcycle(0, 0, 0);
    expect_wr(1, 8'hB1);
    expect_wr(1, 8'hB2);
    expect_wr(1, 8'hB3);
    chk_log("t5");

    // asynchronous reset in the middle of a packet
    do_reset();
    for (int k = 0; k < 4; k++) push_beat(3, DW'(8'hC1 + k), k == 3);
    active[3] = 1'b1;
    qcycle(0, 0, 0);
    qcycle(0, 0, 0);
    chk("pre_rst_busy", 32'(bus.busy), 32'(m_lock));
    #2;
    w_rst = 1'b1;
    #1;
    chk("arst_grant", 32'(bus.grant), 32'(0));
    chk("arst_busy",  32'(bus.busy),  32'(0));
    chk("arst_winc",  32'(bus.winc),  32'(0));
    chk("arst_ack",   32'(bus.ack),   32'(0));
    @(posedge wclk);
    #1;
    do_reset();

    // requester 1 sends 6 beats, requester 3 sends 2
    for (int k = 0; k < 6; k++) push_beat(1, DW'(8'hD1 + k), k == 5);
    push_beat(3, 8'hE1, 1'b0);
    push_beat(3, 8'hE2, 1'b1);
    active[1] = 1'b1;
    qcycle(0, 0, 0);
    active[3] = 1'b1;
    for (int c = 0; c < 14; c++) qcycle(0, 0, 0);
`ifdef WARB_BURST_LIMIT_EN
    for (int k = 0; k < 4; k++) expect_wr(1, DW'(8'hD1 + k));
    expect_wr(3, 8'hE1);
    expect_wr(3, 8'hE2);
    expect_wr(1, 8'hD5);
    expect_wr(1, 8'hD6);
`else
    for (int k = 0; k < 6; k++) expect_wr(1, DW'(8'hD1 + k));
    expect_wr(3, 8'hE1);
    expect_wr(3, 8'hE2);
`endif
    chk_log("burst");

    // randomized traffic with bubbles and backpressure
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (qd[i].size() == 0 && !active[i] && $urandom_range(99) < 8) begin
          n = int'($urandom_range(6, 1));
          for (int k = 0; k < n; k++) push_beat(i, DW'($urandom), k == n - 1);
        end
      end
      qcycle(15, 20, 50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
